// File: rtl/float16_to_fixed.sv
// -----------------------------------------------------------------------------
// float16_to_fixed
//
// Streaming converter from IEEE-754 binary16 to signed two's-complement fixed
// point with FRAC fractional bits. It is a 2-stage pipeline with a valid/ready
// handshake on both sides, full backpressure and one result per cycle.
//
//   S1: decode the operand, align the significand (left or right shift) and
//       capture the guard/round/sticky bits that fall off a right shift.
//   S2: round the magnitude, apply the sign, saturate and raise the flags.
//
// Build option:
//   FLOAT16_TO_FIXED_RNE_EN  defined   -> round to nearest, ties to even.
//                            undefined -> truncate the magnitude toward zero.
//                                         No rounding adder is built.
//
// Parameters:
//   WIDTH  output width in bits, 16..48
//   FRAC   fractional bits of the output, 0..24, FRAC < WIDTH
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-low reset
//   in_valid   in_data is valid
//   in_ready   converter accepts in_data this cycle (independent of in_valid)
//   in_data    FP16 operand {sign, exp[4:0], frac[9:0]}
//   out_valid  result is valid
//   out_ready  consumer accepts the result
//   out_data   signed fixed-point result, FRAC fractional bits
//   out_ovf    result was saturated (finite overflow or +/-Inf)
//   out_nan    operand was NaN (out_data is 0)
// -----------------------------------------------------------------------------
module float16_to_fixed #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan
);

  // Magnitude width. The largest left shift is 11 significand bits moved up
  // by 30 (exp 31 with FRAC 24), i.e. 41 bits; the overflow compare also
  // needs at least one bit above WIDTH (WIDTH <= 48). 50 covers both.
  localparam int MAG_W = 50;

  // Exponent bias (15) plus the 10 fraction bits of the significand.
  localparam logic signed [7:0] SH_OFF = 8'(FRAC - 25);

  // Saturation thresholds on the magnitude and the saturated output codes.
  localparam logic [MAG_W-1:0] POS_MAX = {{(MAG_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [MAG_W-1:0] NEG_MAG = {{(MAG_W-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic r1_valid;
  logic r_out_valid;
  logic w_s2_adv;
  logic w_s1_adv;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // ---------------------------------------------------------------------------
  // S1 combinational: decode and align
  // ---------------------------------------------------------------------------
  logic              w_sign;
  logic [4:0]        w_exp;
  logic [9:0]        w_frac;
  logic              w_is_inf;
  logic              w_is_nan;
  logic [10:0]       w_sig;
  logic [4:0]        w_e;
  logic signed [7:0] w_sh;
  logic [7:0]        w_rsh;
  logic [23:0]       w_ext;
  logic [MAG_W-1:0]  w_mag;
  logic              w_guard;
  logic              w_round;
  logic              w_sticky;

  assign w_sign   = in_data[15];
  assign w_exp    = in_data[14:10];
  assign w_frac   = in_data[9:0];
  assign w_is_inf = (&w_exp) && (w_frac == 10'd0);
  assign w_is_nan = (&w_exp) && (w_frac != 10'd0);

  // NOTE: every output of this block gets a default first, so no path through
  // the if/else chain can leave a signal unassigned and infer a latch.
  always_comb begin
    w_sig    = (w_exp == 5'd0) ? {1'b0, w_frac} : {1'b1, w_frac};
    w_e      = (w_exp == 5'd0) ? 5'd1 : w_exp;
    w_sh     = $signed({3'b000, w_e}) + SH_OFF;
    w_rsh    = -w_sh;
    w_ext    = '0;
    w_mag    = '0;
    w_guard  = 1'b0;
    w_round  = 1'b0;
    w_sticky = 1'b0;
    if (!w_sh[7]) begin
      // Integer result: shift is 0..30, so 5 bits of the amount suffice.
      w_mag = MAG_W'(w_sig) << w_sh[4:0];
    end else if (w_rsh >= 8'd12) begin
      // Every significand bit lies below the round position; the guard bit
      // is necessarily 0, so only stickiness survives.
      w_sticky = |w_sig;
    end else begin
      // Right shift 1..11: the 13 bits below the significand catch the
      // shifted-out bits, topmost is guard, next is round, rest is sticky.
      w_ext    = {w_sig, 13'b0} >> w_rsh[3:0];
      w_mag    = MAG_W'(w_ext[23:13]);
      w_guard  = w_ext[12];
      w_round  = w_ext[11];
      w_sticky = |w_ext[10:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------------
  logic             r1_sign;
  logic             r1_inf;
  logic             r1_nan;
  logic [MAG_W-1:0] r1_mag;
  logic             r1_guard;
  logic             r1_round;
  logic             r1_sticky;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r1_valid <= in_valid;
    end
  end

  // NOTE: the S1 payload has no reset; r1_valid alone qualifies it, so
  // whatever it holds after reset is never observed.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r1_sign   <= w_sign;
      r1_inf    <= w_is_inf;
      r1_nan    <= w_is_nan;
      r1_mag    <= w_mag;
      r1_guard  <= w_guard;
      r1_round  <= w_round;
      r1_sticky <= w_sticky;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 combinational: round, sign, saturate, flags
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0] w_mag_rnd;

`ifdef FLOAT16_TO_FIXED_RNE_EN
  logic w_round_up;

  // Round up when above the halfway point, or exactly halfway with an odd LSB.
  assign w_round_up = r1_guard && (r1_round || r1_sticky || r1_mag[0]);
  assign w_mag_rnd  = r1_mag + MAG_W'(w_round_up);
`else
  // Truncation: the GRS bits are not consumed in this build.
  logic w_unused_grs;

  assign w_unused_grs = r1_guard ^ r1_round ^ r1_sticky;
  assign w_mag_rnd    = r1_mag;
`endif

  logic [WIDTH-1:0] w_res;
  logic             w_res_ovf;
  logic             w_res_nan;

  always_comb begin
    w_res     = '0;
    w_res_ovf = 1'b0;
    w_res_nan = 1'b0;
    if (r1_nan) begin
      w_res_nan = 1'b1;
    end else if (r1_inf) begin
      w_res     = r1_sign ? SAT_MIN : SAT_MAX;
      w_res_ovf = 1'b1;
    end else if (!r1_sign && (w_mag_rnd > POS_MAX)) begin
      w_res     = SAT_MAX;
      w_res_ovf = 1'b1;
    end else if (r1_sign && (w_mag_rnd > NEG_MAG)) begin
      w_res     = SAT_MIN;
      w_res_ovf = 1'b1;
    end else if (r1_sign) begin
      // A magnitude of exactly 2^(WIDTH-1) negates to the minimum code.
      // Negative zero negates to +0.
      w_res = -w_mag_rnd[WIDTH-1:0];
    end else begin
      w_res = w_mag_rnd[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // S2 registers (visible outputs, reset to zero)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_ovf;
  logic             r_out_nan;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_nan   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r1_valid;
      // Payload only moves with a real item, so it holds during stalls.
      if (r1_valid) begin
        r_out_data <= w_res;
        r_out_ovf  <= w_res_ovf;
        r_out_nan  <= w_res_nan;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_nan   = r_out_nan;

endmodule

// File: tb/tb_float16_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_float16_to_fixed
//
// Directed self-checking bench for float16_to_fixed with WIDTH=32, FRAC=16.
// Expected values are hand-computed. Values whose result depends on the
// rounding mode follow FLOAT16_TO_FIXED_RNE_EN.
// -----------------------------------------------------------------------------
module tb_float16_to_fixed;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;

`ifdef FLOAT16_TO_FIXED_RNE_EN
  localparam logic [31:0] EXP_0180 = 32'h0000_0002;  // 1.5 LSB -> 2
  localparam logic [31:0] EXP_0380 = 32'h0000_0004;  // 3.5 LSB -> 4
  localparam logic [31:0] EXP_8180 = 32'hFFFF_FFFE;  // -1.5 LSB -> -2
`else
  localparam logic [31:0] EXP_0180 = 32'h0000_0001;
  localparam logic [31:0] EXP_0380 = 32'h0000_0003;
  localparam logic [31:0] EXP_8180 = 32'hFFFF_FFFF;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;
  logic             out_nan;

  int n_checks = 0;
  int n_errors = 0;

  // Mode-independent stream vectors with their hand-computed results.
  logic [15:0] s_in  [8];
  logic [31:0] s_exp [8];

  float16_to_fixed #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single transfer with out_ready held high; called at posedge+1.
  task automatic send_one(input string tag, input logic [15:0] din,
                          input logic [31:0] exp_d, input logic exp_o, input logic exp_n);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = din;
    #1;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check({tag, "/not_yet"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "/valid"}, 32'(out_valid), 32'd1);
    check({tag, "/data"},  out_data,         exp_d);
    check({tag, "/ovf"},   32'(out_ovf),     32'(exp_o));
    check({tag, "/nan"},   32'(out_nan),     32'(exp_n));
    tick();
  endtask

  initial begin
    int sent;
    int recv;
    int occ;
    logic stalled_prev;
    logic [31:0] held;

    s_in[0] = 16'h3C00; s_exp[0] = 32'h0001_0000;
    s_in[1] = 16'hC100; s_exp[1] = 32'hFFFD_8000;
    s_in[2] = 16'h1C00; s_exp[2] = 32'h0000_0100;
    s_in[3] = 16'h8000; s_exp[3] = 32'h0000_0000;
    s_in[4] = 16'h0280; s_exp[4] = 32'h0000_0002;
    s_in[5] = 16'h0001; s_exp[5] = 32'h0000_0000;
    s_in[6] = 16'h7BFF; s_exp[6] = 32'h7FFF_FFFF;
    s_in[7] = 16'hF800; s_exp[7] = 32'h8000_0000;

    // ---------------- reset state ----------------
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    #10;
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/out_data",  out_data,       32'd0);
    check("reset/out_ovf",   32'(out_ovf),   32'd0);
    check("reset/out_nan",   32'(out_nan),   32'd0);
    #11 rst = 1'b1;
    tick();
    check("reset/in_ready", 32'(in_ready), 32'd1);

    // ---------------- basic values ----------------
    send_one("basic_3c00", 16'h3C00, 32'h0001_0000, 1'b0, 1'b0);
    send_one("basic_c100", 16'hC100, 32'hFFFD_8000, 1'b0, 1'b0);
    send_one("basic_1c00", 16'h1C00, 32'h0000_0100, 1'b0, 1'b0);
    send_one("basic_8000", 16'h8000, 32'h0000_0000, 1'b0, 1'b0);
    send_one("basic_3e00", 16'h3E00, 32'h0001_8000, 1'b0, 1'b0);

    // ---------------- rounding ----------------
    send_one("rnd_0180", 16'h0180, EXP_0180,     1'b0, 1'b0);
    send_one("rnd_0280", 16'h0280, 32'h0000_0002, 1'b0, 1'b0);
    send_one("rnd_0380", 16'h0380, EXP_0380,     1'b0, 1'b0);
    send_one("rnd_8180", 16'h8180, EXP_8180,     1'b0, 1'b0);
    send_one("rnd_0001", 16'h0001, 32'h0000_0000, 1'b0, 1'b0);

    // ---------------- saturation boundaries and specials ----------------
    send_one("sat_7bff", 16'h7BFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
    send_one("sat_7800", 16'h7800, 32'h7FFF_FFFF, 1'b1, 1'b0);
    send_one("fit_77ff", 16'h77FF, 32'h7FF0_0000, 1'b0, 1'b0);
    send_one("fit_f800", 16'hF800, 32'h8000_0000, 1'b0, 1'b0);
    send_one("inf_fc00", 16'hFC00, 32'h8000_0000, 1'b1, 1'b0);
    send_one("inf_7c00", 16'h7C00, 32'h7FFF_FFFF, 1'b1, 1'b0);
    send_one("nan_7e00", 16'h7E00, 32'h0000_0000, 1'b0, 1'b1);

    // ---------------- backpressure ----------------
    sent         = 0;
    recv         = 0;
    stalled_prev = 1'b0;
    held         = '0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? s_in[sent] : 16'h0000;
      #1;
      occ = sent - recv;
      if (stalled_prev) begin
        check("bp/hold_valid", 32'(out_valid), 32'd1);
        check("bp/hold_data",  out_data,       held);
      end
      if (occ == 2 && !out_ready) check("bp/in_ready_full", 32'(in_ready), 32'd0);
      if (out_ready) check("bp/in_ready_drain", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        if (recv < 8) check("bp/data", out_data, s_exp[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = out_valid && !out_ready;
      held         = out_data;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp/received", 32'(recv), 32'd8);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp/no_extra", 32'(out_valid), 32'd0);
      tick();
    end

    // ---------------- back-to-back ----------------
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_valid = (c < 16);
      in_data  = (c < 16) ? s_in[c % 8] : 16'h0000;
      #1;
      if (c < 16) check("b2b/in_ready", 32'(in_ready), 32'd1);
      check("b2b/valid", 32'(out_valid), (c >= 2 && c < 18) ? 32'd1 : 32'd0);
      if (c >= 2 && c < 18) check("b2b/data", out_data, s_exp[(c - 2) % 8]);
      tick();
    end
    in_valid = 1'b0;

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h3C00;
    tick();
    in_data   = 16'hC100;
    tick();
    in_valid  = 1'b0;
    in_data   = '0;
    #1;
    check("rst_mid/in_ready_full", 32'(in_ready),  32'd0);
    check("rst_mid/pre_valid",     32'(out_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_mid/valid_drop", 32'(out_valid), 32'd0);
    check("rst_mid/data_clear", out_data,       32'd0);
    #3 rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_mid/no_stale", 32'(out_valid), 32'd0);
    end
    send_one("rst_mid/first", 16'h3C00, 32'h0001_0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
